aclk_key_decoder: RTL and testbench
===================================

Name: aclk_key_decoder

Overview:
- Receive-side counterpart of the alarm-clock LCD encoder: accepts ASCII key codes (0x30–0x39 digits plus command codes) from the keypad front end and decodes them to BCD.
- Assembles four digits (HH:MM) into a shift buffer and issues one-cycle load strobes to the time counter / alarm register.
- Sits between the keypad interface and the clock FSM / counter; includes an entry timeout.

Parameters:
- TIMEOUT_CYCLES, 1000, idle clock cycles in an entry before the partial entry is discarded (≥2).
- TMR_W, 16, timeout counter width; must hold TIMEOUT_CYCLES.
- CODE_ALARM, 8'h41, ASCII 'A': commit buffer as alarm time.
- CODE_TIME, 8'h54, ASCII 'T': commit buffer as new current time.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_code  in  8  ASCII key code; sampled only when key_valid=1.
- key_valid  in  1  one-cycle strobe per key press.
- key_digit  out  4  last accepted BCD digit.
- key_buffer  out  16  four BCD digits; [15:12] is the oldest digit (hour tens).
- digit_count  out  3  digits held, 0–4.
- shift  out  1  one-cycle pulse per accepted digit.
- load_new_time  out  1  one-cycle commit pulse on a CODE_TIME commit.
- load_alarm  out  1  one-cycle commit pulse on a CODE_ALARM commit.
- key_error  out  1  one-cycle pulse on a rejected key.
- timeout  out  1  one-cycle pulse when an entry is abandoned.

Behaviour:
- Reset (async, reset=0): state=IDLE; key_digit=0, key_buffer=0, digit_count=0, timer=0; all pulse outputs 0.
- All outputs are registered. The response appears on the first rising edge after key_valid is sampled high (latency 1). Pulse outputs are high for exactly one cycle.
- Decode:
  - 0x30–0x39 → digit (code − 0x30).
  - CODE_ALARM and CODE_TIME → commands.
  - Any other code (including 0x3A error glyph) → invalid: key_error=1, no other change, timer not restarted.
- States: IDLE, ENTRY, FULL.
- IDLE:
  - Digit → key_buffer={12'h000,d}, digit_count=1, key_digit=d, shift=1, timer=0, → ENTRY.
  - Command → key_error, stay in IDLE.
- ENTRY:
  - Digit → key_buffer={key_buffer[11:0],d}, digit_count+1, key_digit=d, shift=1, timer=0.
  - When digit_count reaches 4 → FULL.
  - Command → key_error, stay in ENTRY; buffer kept, timer not restarted.
- FULL:
  - Digit → key_error, buffer unchanged (no overwrite or wrap).
  - CODE_TIME → load_new_time=1, → IDLE.
  - CODE_ALARM → load_alarm=1, → IDLE.
  - On commit, key_buffer holds its value through and after the strobe. digit_count clears to 0 in the same edge.
- Timeout, in ENTRY or FULL:
  - Timer increments every cycle without an accepted digit.
  - When timer = TIMEOUT_CYCLES−1 → timeout=1, key_buffer=0, digit_count=0, → IDLE.
  - If a key arrives in the same cycle as expiry, the key is processed and the timeout is suppressed.
  - Timer is held at 0 in IDLE.
- Never asserted simultaneously: load_new_time and load_alarm; key_error and shift.
- reset asserted mid-entry discards everything immediately (async), including in-flight pulses.

Optional Feature:
- Macro: ACLK_RANGE_CHECK_EN.
- Defined:
  - Digits are checked by position before acceptance: position 1 ≤2; position 2 ≤3 if position 1 = 2, else ≤9; position 3 ≤5; position 4 ≤9.
  - A failing digit → key_error, not shifted, timer not restarted.
- Undefined: any 0–9 accepted in any position.

Test Plan:
- Reset, then key_valid with 0x31,0x32,0x33,0x34 then 0x54 → key_buffer=16'h1234, digit_count steps 1..4, four shift pulses, then load_new_time=1 for one cycle, state IDLE.
- From IDLE enter 0x30,0x37 then 0x41 → key_error=1, no load_alarm, buffer 16'h0007; add 0x33,0x30,0x41 → load_alarm=1, key_buffer=16'h0730.
- Fifth digit 0x39 after 0x31,0x32,0x30,0x30 → key_error=1, key_buffer stays 16'h1200.
- 0x3A and 0x7F in ENTRY → key_error each time, digit_count unchanged.
- Enter 0x35 with TIMEOUT_CYCLES=8 and no further keys → timeout pulse 8 cycles after the digit, buffer 0, digit_count 0; repeat with a digit arriving in the expiry cycle → no timeout.
- With ACLK_RANGE_CHECK_EN: 0x32,0x34 → second digit rejected with key_error; 0x32,0x33,0x36 → third digit rejected. Assert reset mid-entry → all outputs 0 immediately.

Source files
------------

// File: rtl/aclk_key_decoder.sv
// Alarm-clock keypad decoder: ASCII keys -> BCD HH:MM buffer with load strobes and entry timeout.
// Optional per-position digit range checking is enabled by defining ACLK_RANGE_CHECK_EN.
module aclk_key_decoder #(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         TMR_W          = 16,
  parameter logic [7:0] CODE_ALARM     = 8'h41,
  parameter logic [7:0] CODE_TIME      = 8'h54
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  output logic [3:0]  key_digit,
  output logic [15:0] key_buffer,
  output logic [2:0]  digit_count,
  output logic        shift,
  output logic        load_new_time,
  output logic        load_alarm,
  output logic        key_error,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_key_digit,   w_digit_nxt;
  logic [15:0]        r_key_buffer,  w_buffer_nxt;
  logic [2:0]         r_digit_count, w_count_nxt;
  logic [TMR_W-1:0]   r_timer,       w_timer_nxt;
  logic               r_shift,       w_shift_nxt;
  logic               r_load_time,   w_load_time_nxt;
  logic               r_load_alarm,  w_load_alarm_nxt;
  logic               r_key_error,   w_key_error_nxt;
  logic               r_timeout,     w_timeout_nxt;

  logic               w_is_digit;
  logic               w_is_cmd;
  logic [3:0]         w_digit;
  logic               w_range_ok;
  logic               w_expired;

  assign w_is_digit = (key_code >= 8'h30) && (key_code <= 8'h39);
  assign w_is_cmd   = (key_code == CODE_ALARM) || (key_code == CODE_TIME);
  assign w_digit    = key_code[3:0];
  assign w_expired  = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  // Position-dependent digit legality for the next slot (slot = digits held + 1).
  always_comb begin
    w_range_ok = 1'b1;
`ifdef ACLK_RANGE_CHECK_EN
    case (r_digit_count)
      3'd0:    w_range_ok = (w_digit <= 4'd2);
      3'd1:    w_range_ok = (r_key_buffer[3:0] == 4'd2) ? (w_digit <= 4'd3) : 1'b1;
      3'd2:    w_range_ok = (w_digit <= 4'd5);
      default: w_range_ok = 1'b1;
    endcase
`else
    w_range_ok = 1'b1;
`endif
  end

  // Next-state and next-output computation for the entry FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_digit_nxt      = r_key_digit;
    w_buffer_nxt     = r_key_buffer;
    w_count_nxt      = r_digit_count;
    w_timer_nxt      = r_timer;
    w_shift_nxt      = 1'b0;
    w_load_time_nxt  = 1'b0;
    w_load_alarm_nxt = 1'b0;
    w_key_error_nxt  = 1'b0;
    w_timeout_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = {TMR_W{1'b0}};
        if (key_valid && w_is_digit && w_range_ok) begin
          w_buffer_nxt = {12'h000, w_digit};
          w_count_nxt  = 3'd1;
          w_digit_nxt  = w_digit;
          w_shift_nxt  = 1'b1;
          w_state_nxt  = ST_ENTRY;
        end else if (key_valid) begin
          w_key_error_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ENTRY, ST_FULL: begin
        if (key_valid && w_is_digit && w_range_ok && (r_state == ST_ENTRY)) begin
          w_buffer_nxt = {r_key_buffer[11:0], w_digit};
          w_count_nxt  = r_digit_count + 3'd1;
          w_digit_nxt  = w_digit;
          w_shift_nxt  = 1'b1;
          w_timer_nxt  = {TMR_W{1'b0}};
          w_state_nxt  = (r_digit_count == 3'd3) ? ST_FULL : ST_ENTRY;
        end else if (key_valid && w_is_cmd && (r_state == ST_FULL)) begin
          w_load_time_nxt  = (key_code == CODE_TIME);
          w_load_alarm_nxt = (key_code == CODE_ALARM);
          w_count_nxt      = 3'd0;
          w_timer_nxt      = {TMR_W{1'b0}};
          w_state_nxt      = ST_IDLE;
        end else if (key_valid) begin
          // A rejected key in the expiry cycle still suppresses the timeout; hold so it fires next cycle.
          w_key_error_nxt = 1'b1;
          w_timer_nxt     = w_expired ? r_timer : (r_timer + TMR_W'(1));
        end else if (w_expired) begin
          w_timeout_nxt = 1'b1;
          w_buffer_nxt  = 16'h0000;
          w_count_nxt   = 3'd0;
          w_timer_nxt   = {TMR_W{1'b0}};
          w_state_nxt   = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_buffer_nxt = 16'h0000;
        w_count_nxt  = 3'd0;
        w_timer_nxt  = {TMR_W{1'b0}};
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_key_digit   <= 4'h0;
      r_key_buffer  <= 16'h0000;
      r_digit_count <= 3'd0;
      r_timer       <= {TMR_W{1'b0}};
      r_shift       <= 1'b0;
      r_load_time   <= 1'b0;
      r_load_alarm  <= 1'b0;
      r_key_error   <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_key_digit   <= w_digit_nxt;
      r_key_buffer  <= w_buffer_nxt;
      r_digit_count <= w_count_nxt;
      r_timer       <= w_timer_nxt;
      r_shift       <= w_shift_nxt;
      r_load_time   <= w_load_time_nxt;
      r_load_alarm  <= w_load_alarm_nxt;
      r_key_error   <= w_key_error_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign key_digit     = r_key_digit;
  assign key_buffer    = r_key_buffer;
  assign digit_count   = r_digit_count;
  assign shift         = r_shift;
  assign load_new_time = r_load_time;
  assign load_alarm    = r_load_alarm;
  assign key_error     = r_key_error;
  assign timeout       = r_timeout;

endmodule

// File: tb/tb_aclk_key_decoder.sv
// Self-checking bench for aclk_key_decoder: directed scenarios plus random keys vs a queue-based model.
module tb_aclk_key_decoder;
  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit;
  logic [15:0] key_buffer;
  logic [2:0]  digit_count;
  logic        shift, load_new_time, load_alarm, key_error, timeout;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: digits held in a queue, idle cycles since the last accepted digit.
  int          m_digits[$];
  int          m_idle;
  logic [15:0] m_buf;
  logic [3:0]  m_digit;
  logic        e_shift, e_lt, e_la, e_err, e_to;

  logic [27:0] dut_vec, exp_vec;
  assign dut_vec = {key_digit, key_buffer, digit_count, shift, load_new_time, load_alarm, key_error, timeout};
  assign exp_vec = {m_digit, m_buf, 3'(m_digits.size()), e_shift, e_lt, e_la, e_err, e_to};

  aclk_key_decoder #(.TIMEOUT_CYCLES(TMO), .TMR_W(16), .CODE_ALARM(8'h41), .CODE_TIME(8'h54)) dut (
    .clock(clock), .reset(reset), .key_code(key_code), .key_valid(key_valid),
    .key_digit(key_digit), .key_buffer(key_buffer), .digit_count(digit_count),
    .shift(shift), .load_new_time(load_new_time), .load_alarm(load_alarm),
    .key_error(key_error), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    m_digits.delete();
    m_idle = 0; m_buf = 16'h0000; m_digit = 4'h0;
    e_shift = 1'b0; e_lt = 1'b0; e_la = 1'b0; e_err = 1'b0; e_to = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] c);
    int   n;
    logic isd, ok;
    logic [3:0] d;
    n = m_digits.size();
    isd = (c >= 8'h30) && (c <= 8'h39);
    d = c[3:0];
    ok = 1'b1;
`ifdef ACLK_RANGE_CHECK_EN
    if (n == 0) ok = (d <= 4'd2);
    else if (n == 1) ok = (m_digits[0] == 2) ? (d <= 4'd3) : 1'b1;
    else if (n == 2) ok = (d <= 4'd5);
`endif
    e_shift = 1'b0; e_lt = 1'b0; e_la = 1'b0; e_err = 1'b0; e_to = 1'b0;
    if (v && isd && n < 4 && ok) begin
      m_digits.push_back(int'(d));
      m_buf = 16'h0000;
      foreach (m_digits[i]) m_buf = 16'(m_buf * 16 + m_digits[i]);
      m_digit = d; e_shift = 1'b1; m_idle = 0;
    end else if (v && (c == 8'h41 || c == 8'h54) && n == 4) begin
      e_lt = (c == 8'h54); e_la = (c == 8'h41);
      m_digits.delete(); m_idle = 0;
    end else if (v) begin
      e_err = 1'b1;
      if (n > 0 && m_idle < TMO - 1) m_idle++;
    end else if (n > 0) begin
      if (m_idle == TMO - 1) begin
        e_to = 1'b1; m_digits.delete(); m_buf = 16'h0000; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  endtask

  // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] c);
    @(negedge clock);
    key_valid = v; key_code = c;
    model_step(v, c);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (dut_vec !== 28'h0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, 28'h0);
    end
  endtask

  task automatic test_time_commit();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h31 + i));
      n_cmp++;
      if (digit_count !== 3'(i + 1) || shift !== 1'b1 || key_error !== 1'b0) begin
        n_fail++; $display("FAIL time_digit%0d: count=%0d shift=%b err=%b expected count=%0d shift=1", i, digit_count, shift, key_error, i + 1);
      end
    end
    step(1'b1, 8'h54);
    n_cmp++;
    if (load_new_time !== 1'b1 || load_alarm !== 1'b0 || key_buffer !== 16'h1234 || digit_count !== 3'd0) begin
      n_fail++; $display("FAIL time_commit: lt=%b la=%b buf=%h cnt=%0d expected 1 0 1234 0", load_new_time, load_alarm, key_buffer, digit_count);
    end
    step(1'b0, 8'h00);
    n_cmp++;
    if (load_new_time !== 1'b0 || key_buffer !== 16'h1234) begin
      n_fail++; $display("FAIL time_pulse_width: lt=%b buf=%h expected 0 1234", load_new_time, key_buffer);
    end
  endtask

  task automatic test_alarm();
    step(1'b1, 8'h30);
    step(1'b1, 8'h37);
    step(1'b1, 8'h41);
    n_cmp++;
    if (key_error !== 1'b1 || load_alarm !== 1'b0 || key_buffer !== 16'h0007 || digit_count !== 3'd2) begin
      n_fail++; $display("FAIL alarm_early_cmd: err=%b la=%b buf=%h cnt=%0d expected 1 0 0007 2", key_error, load_alarm, key_buffer, digit_count);
    end
    step(1'b1, 8'h33);
    step(1'b1, 8'h30);
    step(1'b1, 8'h41);
    n_cmp++;
    if (load_alarm !== 1'b1 || load_new_time !== 1'b0 || key_buffer !== 16'h0730) begin
      n_fail++; $display("FAIL alarm_commit: la=%b lt=%b buf=%h expected 1 0 0730", load_alarm, load_new_time, key_buffer);
    end
  endtask

  task automatic test_full();
    step(1'b1, 8'h31); step(1'b1, 8'h32); step(1'b1, 8'h30); step(1'b1, 8'h30);
    step(1'b1, 8'h39);
    n_cmp++;
    if (key_error !== 1'b1 || shift !== 1'b0 || key_buffer !== 16'h1200 || digit_count !== 3'd4) begin
      n_fail++; $display("FAIL full_fifth_digit: err=%b shift=%b buf=%h cnt=%0d expected 1 0 1200 4", key_error, shift, key_buffer, digit_count);
    end
    step(1'b1, 8'h54);
  endtask

  task automatic test_invalid();
    step(1'b1, 8'h31);
    step(1'b1, 8'h3A);
    n_cmp++;
    if (key_error !== 1'b1 || digit_count !== 3'd1) begin
      n_fail++; $display("FAIL invalid_3A: err=%b cnt=%0d expected 1 1", key_error, digit_count);
    end
    step(1'b1, 8'h7F);
    n_cmp++;
    if (key_error !== 1'b1 || digit_count !== 3'd1 || key_buffer !== 16'h0001) begin
      n_fail++; $display("FAIL invalid_7F: err=%b cnt=%0d buf=%h expected 1 1 0001", key_error, digit_count, key_buffer);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    logic [7:0] first;
`ifdef ACLK_RANGE_CHECK_EN
    first = 8'h31;
`else
    first = 8'h35;
`endif
    step(1'b1, first);
    for (int i = 1; i < TMO; i++) begin
      step(1'b0, 8'h00);
      n_cmp++;
      if (timeout !== 1'b0 || digit_count !== 3'd1) begin
        n_fail++; $display("FAIL timeout_early_c%0d: to=%b cnt=%0d expected 0 1", i, timeout, digit_count);
      end
    end
    step(1'b0, 8'h00);
    n_cmp++;
    if (timeout !== 1'b1 || key_buffer !== 16'h0000 || digit_count !== 3'd0) begin
      n_fail++; $display("FAIL timeout_expiry: to=%b buf=%h cnt=%0d expected 1 0000 0", timeout, key_buffer, digit_count);
    end
    step(1'b0, 8'h00);
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse_width: to=%b expected 0", timeout);
    end
    step(1'b1, first);
    for (int i = 1; i < TMO; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h31);
    n_cmp++;
    if (timeout !== 1'b0 || shift !== 1'b1 || digit_count !== 3'd2) begin
      n_fail++; $display("FAIL timeout_suppressed: to=%b shift=%b cnt=%0d expected 0 1 2", timeout, shift, digit_count);
    end
    do_reset();
  endtask

`ifdef ACLK_RANGE_CHECK_EN
  task automatic test_range();
    step(1'b1, 8'h32);
    step(1'b1, 8'h34);
    n_cmp++;
    if (key_error !== 1'b1 || shift !== 1'b0 || digit_count !== 3'd1) begin
      n_fail++; $display("FAIL range_pos2: err=%b shift=%b cnt=%0d expected 1 0 1", key_error, shift, digit_count);
    end
    do_reset();
    step(1'b1, 8'h32); step(1'b1, 8'h33);
    step(1'b1, 8'h36);
    n_cmp++;
    if (key_error !== 1'b1 || digit_count !== 3'd2 || key_buffer !== 16'h0023) begin
      n_fail++; $display("FAIL range_pos3: err=%b cnt=%0d buf=%h expected 1 2 0023", key_error, digit_count, key_buffer);
    end
    do_reset();
  endtask
`endif

  task automatic test_random();
    logic [7:0] c;
    logic       v;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 9))
        0:       c = 8'h41;
        1:       c = 8'h54;
        2:       c = 8'($urandom_range(0, 255));
        default: c = 8'(8'h30 + $urandom_range(0, 9));
      endcase
      step(v, c);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL random_c%0d: got %h expected %h (v=%b code=%h)", i, dut_vec, exp_vec, v, c);
      end
    end
  endtask

  task automatic test_reset_mid_entry();
    step(1'b1, 8'h31);
    step(1'b1, 8'h32);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 28'h0) begin
      n_fail++; $display("FAIL reset_mid_entry: got %h expected %h", dut_vec, 28'h0);
    end
    model_clear();
    @(negedge clock);
    reset = 1'b1; key_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_time_commit();
    test_alarm();
    test_full();
    test_invalid();
    test_timeout();
`ifdef ACLK_RANGE_CHECK_EN
    test_range();
`endif
    test_random();
    test_reset_mid_entry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
